// File: rtl/bank_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bank_cmd_sequencer_pkg
// Description : Shared types for the DRAM bank command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef BA_BITS
`define BA_BITS 2
`endif

package bank_cmd_sequencer_pkg;

    localparam int BA_BITS = `BA_BITS;
    localparam int NB      = 1 << BA_BITS;
    localparam int ROW_W   = 8;
    localparam int COL_W   = 8;
    localparam int ADDR_W  = ROW_W + COL_W;

    typedef enum logic [2:0] {
        SCH_NOP       = 3'd0,
        SCH_ACTIVE    = 3'd1,
        SCH_READ      = 3'd2,
        SCH_WRITE     = 3'd3,
        SCH_RDA       = 3'd4,
        SCH_WRA       = 3'd5,
        SCH_PRECHARGE = 3'd6,
        SCH_REFRESH   = 3'd7
    } sch_cmd_t;

    // r_w = 1 selects a read, 0 a write
    typedef struct packed {
        logic               r_w;
        logic [ROW_W-1:0]   row;
        logic [COL_W-1:0]   col;
        logic [BA_BITS-1:0] bank;
        logic               auto_precharge;
    } command_t;

    typedef struct packed {
        sch_cmd_t           command;
        logic [ADDR_W-1:0]  addr;
        logic [BA_BITS-1:0] bank;
    } issue_fifo_cmd_in_t;

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_PRE         = 4'd1,
        S_WAIT_RP     = 4'd2,
        S_ACT         = 4'd3,
        S_WAIT_RCD    = 4'd4,
        S_RW          = 4'd5,
        S_REF_PRE     = 4'd6,
        S_REF_WAIT_RP = 4'd7,
        S_REF         = 4'd8,
        S_WAIT_RFC    = 4'd9
    } seq_state_t;

    function automatic sch_cmd_t rw_cmd(input logic r_w, input logic ap);
        if (r_w) return ap ? SCH_RDA : SCH_READ;
        return ap ? SCH_WRA : SCH_WRITE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bank_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : bank_cmd_sequencer_if
// Description : Host command, issue FIFO and refresh handshakes of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface bank_cmd_sequencer_if;

    logic                                         cmd_valid;
    logic                                         cmd_ready;
    bank_cmd_sequencer_pkg::command_t             cmd_in;
    logic                                         iss_valid;
    logic                                         iss_ready;
    bank_cmd_sequencer_pkg::issue_fifo_cmd_in_t   iss_cmd;
    logic                                         ref_req;
    logic                                         ref_ack;
    logic                                         busy;

    modport master (
        output cmd_valid, cmd_in, iss_ready, ref_req,
        input  cmd_ready, iss_valid, iss_cmd, ref_ack, busy
    );

    modport slave (
        input  cmd_valid, cmd_in, iss_ready, ref_req,
        output cmd_ready, iss_valid, iss_cmd, ref_ack, busy
    );

endinterface

`default_nettype wire

// File: rtl/bank_cmd_sequencer_ras_timer.sv
`default_nettype none
// ============================================================================
// Module      : bank_ras_timer
// Description : Per-bank tRAS down-counter with load, decrement and zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module bank_ras_timer #(
    parameter int CNT_W  = 6,
    parameter int T_LOAD = 9
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_load,
    input  wire logic i_dec,
    output logic      o_zero
);

    localparam logic [CNT_W-1:0] c_load = CNT_W'(T_LOAD);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_load;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/bank_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bank_cmd_sequencer
// Description : Turns host DRAM requests into timed bank commands (open-page).
// Revision    : 1.0 - initial release
// ============================================================================
module bank_cmd_sequencer
    import bank_cmd_sequencer_pkg::*;
#(
    parameter int T_RCD = 4,
    parameter int T_RP  = 4,
    parameter int T_RAS = 10,
    parameter int T_RFC = 30,
    parameter int CNT_W = 6
) (
    input  wire logic             clk,
    input  wire logic             rst,
    bank_cmd_sequencer_if.slave   bus
);

    // Wait states last T-1 cycles so the follow-on command is valid at transfer+T
    localparam logic [CNT_W-1:0]   c_rcd_ld  = CNT_W'(T_RCD - 2);
    localparam logic [CNT_W-1:0]   c_rp_ld   = CNT_W'(T_RP - 2);
    localparam logic [CNT_W-1:0]   c_rfc_ld  = CNT_W'(T_RFC - 1);
    localparam logic [BA_BITS-1:0] c_last_ba = BA_BITS'(NB - 1);

    seq_state_t          r_state, w_state_nxt;
    command_t            r_cmd;
    logic [CNT_W-1:0]    r_wait, w_wait_nxt;
    logic [BA_BITS-1:0]  r_scan, w_scan_nxt;
    logic                r_any_pre, w_any_pre_nxt;
    logic                r_rp_to_idle, w_rp_to_idle_nxt;
    logic [NB-1:0]       r_open;
    logic [ROW_W-1:0]    r_row [NB];

    logic                w_cmd_ready;
    logic                w_accept;
    logic                w_act_en;
    logic                w_close_en;
    logic [BA_BITS-1:0]  w_close_bank;
    logic [NB-1:0]       w_ras_zero;
    logic                w_iss_valid;
    issue_fifo_cmd_in_t  w_iss_cmd;
    logic                w_ref_ack;
    logic [ADDR_W-1:0]   w_cmd_addr;

    assign w_cmd_ready = (r_state == S_IDLE) && !bus.ref_req && !rst;
    assign w_accept    = w_cmd_ready && bus.cmd_valid;
    assign w_cmd_addr  = {r_cmd.row, r_cmd.col};

    // Loaded with T_RAS-1 so the zero flag is first seen at ACT transfer + T_RAS
    for (genvar b = 0; b < NB; b++) begin : g_bank
        bank_ras_timer #(
            .CNT_W  (CNT_W),
            .T_LOAD (T_RAS - 1)
        ) u_ras (
            .clk    (clk),
            .rst    (rst),
            .i_load (w_act_en && (r_cmd.bank == BA_BITS'(b))),
            .i_dec  (1'b1),
            .o_zero (w_ras_zero[b])
        );
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_wait_nxt       = (r_wait != '0) ? r_wait - CNT_W'(1) : '0;
        w_scan_nxt       = r_scan;
        w_any_pre_nxt    = r_any_pre;
        w_rp_to_idle_nxt = r_rp_to_idle;
        w_act_en         = 1'b0;
        w_close_en       = 1'b0;
        w_close_bank     = r_cmd.bank;
        w_iss_valid      = 1'b0;
        w_iss_cmd        = '0;
        w_ref_ack        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.ref_req) begin
                    w_state_nxt   = S_REF_PRE;
                    w_scan_nxt    = '0;
                    w_any_pre_nxt = 1'b0;
                end else if (w_accept) begin
                    if (!r_open[bus.cmd_in.bank])
                        w_state_nxt = S_ACT;
                    else if (r_row[bus.cmd_in.bank] == bus.cmd_in.row)
                        w_state_nxt = S_RW;
                    else
                        w_state_nxt = S_PRE;
                end
            end
            S_PRE: begin
                w_iss_valid       = w_ras_zero[r_cmd.bank];
                w_iss_cmd.command = SCH_PRECHARGE;
                w_iss_cmd.addr    = w_cmd_addr;
                w_iss_cmd.bank    = r_cmd.bank;
                if (w_ras_zero[r_cmd.bank] && bus.iss_ready) begin
                    w_close_en       = 1'b1;
                    w_rp_to_idle_nxt = 1'b0;
                    w_wait_nxt       = c_rp_ld;
                    w_state_nxt      = S_WAIT_RP;
                end
            end
            S_WAIT_RP: begin
                if (r_wait == '0)
                    w_state_nxt = r_rp_to_idle ? S_IDLE : S_ACT;
            end
            S_ACT: begin
                w_iss_valid       = 1'b1;
                w_iss_cmd.command = SCH_ACTIVE;
                w_iss_cmd.addr    = w_cmd_addr;
                w_iss_cmd.bank    = r_cmd.bank;
                if (bus.iss_ready) begin
                    w_act_en    = 1'b1;
                    w_wait_nxt  = c_rcd_ld;
                    w_state_nxt = S_WAIT_RCD;
                end
            end
            S_WAIT_RCD: begin
                if (r_wait == '0)
                    w_state_nxt = S_RW;
            end
            S_RW: begin
                w_iss_cmd.command = rw_cmd(r_cmd.r_w, r_cmd.auto_precharge);
                w_iss_cmd.addr    = w_cmd_addr;
                w_iss_cmd.bank    = r_cmd.bank;
                if (r_cmd.auto_precharge) begin
                    w_iss_valid = w_ras_zero[r_cmd.bank];
                    if (w_ras_zero[r_cmd.bank] && bus.iss_ready) begin
                        w_close_en       = 1'b1;
                        w_rp_to_idle_nxt = 1'b1;
                        w_wait_nxt       = c_rp_ld;
                        w_state_nxt      = S_WAIT_RP;
                    end
                end else begin
                    w_iss_valid = 1'b1;
                    if (bus.iss_ready)
                        w_state_nxt = S_IDLE;
                end
            end
            S_REF_PRE: begin
                // One bank per cycle; open banks hold the scan until their PRE transfers
                if (r_open[r_scan]) begin
                    w_iss_valid       = w_ras_zero[r_scan];
                    w_iss_cmd.command = SCH_PRECHARGE;
                    w_iss_cmd.addr    = w_cmd_addr;
                    w_iss_cmd.bank    = r_scan;
                    if (w_ras_zero[r_scan] && bus.iss_ready) begin
                        w_close_en    = 1'b1;
                        w_close_bank  = r_scan;
                        w_any_pre_nxt = 1'b1;
                        if (r_scan == c_last_ba) begin
                            w_wait_nxt  = c_rp_ld;
                            w_state_nxt = S_REF_WAIT_RP;
                        end else begin
                            w_scan_nxt = r_scan + BA_BITS'(1);
                        end
                    end
                end else if (r_scan == c_last_ba) begin
                    if (r_any_pre) begin
                        w_wait_nxt  = c_rp_ld;
                        w_state_nxt = S_REF_WAIT_RP;
                    end else begin
                        w_state_nxt = S_REF;
                    end
                end else begin
                    w_scan_nxt = r_scan + BA_BITS'(1);
                end
            end
            S_REF_WAIT_RP: begin
                if (r_wait == '0)
                    w_state_nxt = S_REF;
            end
            S_REF: begin
                w_iss_valid       = 1'b1;
                w_iss_cmd.command = SCH_REFRESH;
                if (bus.iss_ready) begin
                    w_wait_nxt  = c_rfc_ld;
                    w_state_nxt = S_WAIT_RFC;
                end
            end
            S_WAIT_RFC: begin
                if (r_wait == '0) begin
                    w_ref_ack   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cmd        <= '0;
            r_wait       <= '0;
            r_scan       <= '0;
            r_any_pre    <= 1'b0;
            r_rp_to_idle <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wait       <= w_wait_nxt;
            r_scan       <= w_scan_nxt;
            r_any_pre    <= w_any_pre_nxt;
            r_rp_to_idle <= w_rp_to_idle_nxt;
            if (w_accept)
                r_cmd <= bus.cmd_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_open <= '0;
            for (int b = 0; b < NB; b++)
                r_row[b] <= '0;
        end else begin
            if (w_act_en) begin
                r_open[r_cmd.bank] <= 1'b1;
                r_row[r_cmd.bank]  <= r_cmd.row;
            end
            if (w_close_en)
                r_open[w_close_bank] <= 1'b0;
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.iss_valid = w_iss_valid;
    assign bus.iss_cmd   = w_iss_cmd;
    assign bus.ref_ack   = w_ref_ack;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_bank_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bank_cmd_sequencer
// Description : Directed vector bench for bank_cmd_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bank_cmd_sequencer;
    import bank_cmd_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    bank_cmd_sequencer_if bus_if ();

    bank_cmd_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic               cv;
        command_t           cin;
        logic               exp_ready;
        logic               exp_valid;
        issue_fifo_cmd_in_t exp_cmd;
        logic               exp_busy;
    } vec_t;

    vec_t vecs [21];

    function automatic command_t mk_cmd(input logic rw, input logic [7:0] row,
                                        input logic [7:0] col, input logic [1:0] ba,
                                        input logic ap);
        command_t c;
        c.r_w = rw; c.row = row; c.col = col; c.bank = ba; c.auto_precharge = ap;
        return c;
    endfunction

    function automatic issue_fifo_cmd_in_t mk_iss(input sch_cmd_t k, input logic [7:0] row,
                                                  input logic [7:0] col, input logic [1:0] ba);
        issue_fifo_cmd_in_t c;
        c.command = k; c.addr = {row, col}; c.bank = ba;
        return c;
    endfunction

    function automatic vec_t mkv(input logic cv, input command_t cin, input logic er,
                                 input logic ev, input issue_fifo_cmd_in_t ec, input logic eb);
        vec_t v;
        v.cv = cv; v.cin = cin; v.exp_ready = er; v.exp_valid = ev; v.exp_cmd = ec; v.exp_busy = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Called just after a posedge; leaves just after the posedge following acceptance
    task automatic send_cmd(input command_t c, output int acc);
        acc = -1;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_in    = c;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus_if.cmd_ready) begin
                acc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        if (acc < 0) begin
            n_chk++; n_fail++;
            $display("FAIL send_cmd_timeout: got no accept expected accept");
        end else begin
            @(posedge clk); #1;
        end
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_iss(output int xc, output issue_fifo_cmd_in_t ic);
        xc = -1;
        ic = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus_if.iss_valid && bus_if.iss_ready) begin
                xc = cyc;
                ic = bus_if.iss_cmd;
                break;
            end
            @(posedge clk); #1;
        end
        if (xc < 0) begin
            n_chk++; n_fail++;
            $display("FAIL wait_iss_timeout: got no transfer expected transfer");
        end else begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        command_t r15, w20;
        issue_fifo_cmd_in_t nc, ic;
        int c0, acc, xc, act3, pre3, refc, ackc;

        r15 = mk_cmd(1'b1, 8'h15, 8'h08, 2'd2, 1'b0);
        w20 = mk_cmd(1'b0, 8'h20, 8'h03, 2'd2, 1'b0);
        nc  = '0;
        vecs[0]  = mkv(1'b1, r15, 1'b1, 1'b0, nc, 1'b0);
        vecs[1]  = mkv(1'b0, r15, 1'b0, 1'b1, mk_iss(SCH_ACTIVE, 8'h15, 8'h08, 2'd2), 1'b1);
        vecs[2]  = mkv(1'b0, r15, 1'b0, 1'b0, nc, 1'b1);
        vecs[3]  = mkv(1'b0, r15, 1'b0, 1'b0, nc, 1'b1);
        vecs[4]  = mkv(1'b0, r15, 1'b0, 1'b0, nc, 1'b1);
        vecs[5]  = mkv(1'b0, r15, 1'b0, 1'b1, mk_iss(SCH_READ, 8'h15, 8'h08, 2'd2), 1'b1);
        vecs[6]  = mkv(1'b1, r15, 1'b1, 1'b0, nc, 1'b0);
        vecs[7]  = mkv(1'b1, w20, 1'b0, 1'b1, mk_iss(SCH_READ, 8'h15, 8'h08, 2'd2), 1'b1);
        vecs[8]  = mkv(1'b1, w20, 1'b1, 1'b0, nc, 1'b0);
        vecs[9]  = mkv(1'b0, w20, 1'b0, 1'b0, nc, 1'b1);
        vecs[10] = mkv(1'b0, w20, 1'b0, 1'b0, nc, 1'b1);
        vecs[11] = mkv(1'b0, w20, 1'b0, 1'b1, mk_iss(SCH_PRECHARGE, 8'h20, 8'h03, 2'd2), 1'b1);
        vecs[12] = mkv(1'b0, w20, 1'b0, 1'b0, nc, 1'b1);
        vecs[13] = mkv(1'b0, w20, 1'b0, 1'b0, nc, 1'b1);
        vecs[14] = mkv(1'b0, w20, 1'b0, 1'b0, nc, 1'b1);
        vecs[15] = mkv(1'b0, w20, 1'b0, 1'b1, mk_iss(SCH_ACTIVE, 8'h20, 8'h03, 2'd2), 1'b1);
        vecs[16] = mkv(1'b0, w20, 1'b0, 1'b0, nc, 1'b1);
        vecs[17] = mkv(1'b0, w20, 1'b0, 1'b0, nc, 1'b1);
        vecs[18] = mkv(1'b0, w20, 1'b0, 1'b0, nc, 1'b1);
        vecs[19] = mkv(1'b0, w20, 1'b0, 1'b1, mk_iss(SCH_WRITE, 8'h20, 8'h03, 2'd2), 1'b1);
        vecs[20] = mkv(1'b0, w20, 1'b1, 1'b0, nc, 1'b0);

        rst = 1'b1;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_in    = '0;
        bus_if.iss_ready = 1'b1;
        bus_if.ref_req   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(bus_if.cmd_ready), 0);
        chk("rst_iss_valid", 32'(bus_if.iss_valid), 0);
        chk("rst_iss_cmd",   32'(bus_if.iss_cmd),   0);
        chk("rst_ref_ack",   32'(bus_if.ref_ack),   0);
        chk("rst_busy",      32'(bus_if.busy),      0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Miss on closed bank, row hit, then row miss with tRAS-gated PRE
        c0 = cyc;
        for (int i = 0; i < 21; i++) begin
            bus_if.cmd_valid = vecs[i].cv;
            bus_if.cmd_in    = vecs[i].cin;
            @(negedge clk);
            chk($sformatf("v%0d_cycle", i), 32'(cyc - c0), 32'(i));
            chk($sformatf("v%0d_cmd_ready", i), 32'(bus_if.cmd_ready), 32'(vecs[i].exp_ready));
            chk($sformatf("v%0d_iss_valid", i), 32'(bus_if.iss_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_busy", i),      32'(bus_if.busy),      32'(vecs[i].exp_busy));
            chk($sformatf("v%0d_ref_ack", i),   32'(bus_if.ref_ack),   0);
            if (vecs[i].exp_valid)
                chk($sformatf("v%0d_iss_cmd", i), 32'(bus_if.iss_cmd), 32'(vecs[i].exp_cmd));
            @(posedge clk); #1;
        end
        bus_if.cmd_valid = 1'b0;

        // Auto-precharge on a row hit: RDA waits for tRAS (ACT at c0+15)
        send_cmd(mk_cmd(1'b1, 8'h20, 8'h05, 2'd2, 1'b1), acc);
        wait_iss(xc, ic);
        chk("rda_cycle", 32'(xc - c0), 25);
        chk("rda_cmd", 32'(ic), 32'(mk_iss(SCH_RDA, 8'h20, 8'h05, 2'd2)));
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("rda_ready_p%0d", k), 32'(bus_if.cmd_ready), (k == 4) ? 1 : 0);
            @(posedge clk); #1;
        end
        send_cmd(mk_cmd(1'b1, 8'h20, 8'h05, 2'd2, 1'b0), acc);
        wait_iss(xc, ic);
        chk("after_rda_act_cycle", 32'(xc - acc), 1);
        chk("after_rda_act_cmd", 32'(ic), 32'(mk_iss(SCH_ACTIVE, 8'h20, 8'h05, 2'd2)));
        acc = xc;
        wait_iss(xc, ic);
        chk("after_rda_rd_cycle", 32'(xc - acc), 4);
        chk("after_rda_rd_cmd", 32'(ic), 32'(mk_iss(SCH_READ, 8'h20, 8'h05, 2'd2)));

        // Back-pressure on ACTIVE
        send_cmd(mk_cmd(1'b1, 8'h07, 8'h02, 2'd1, 1'b0), acc);
        bus_if.iss_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_valid", k), 32'(bus_if.iss_valid), 1);
            chk($sformatf("stall%0d_cmd", k), 32'(bus_if.iss_cmd),
                32'(mk_iss(SCH_ACTIVE, 8'h07, 8'h02, 2'd1)));
            @(posedge clk); #1;
        end
        bus_if.iss_ready = 1'b1;
        wait_iss(xc, ic);
        chk("stall_act_cycle", 32'(xc - acc), 4);
        acc = xc;
        wait_iss(xc, ic);
        chk("stall_rd_cycle", 32'(xc - acc), 4);
        chk("stall_rd_cmd", 32'(ic), 32'(mk_iss(SCH_READ, 8'h07, 8'h02, 2'd1)));

        // Asynchronous reset inside S_WAIT_RCD
        send_cmd(mk_cmd(1'b1, 8'h11, 8'h00, 2'd3, 1'b0), acc);
        wait_iss(xc, ic);
        chk("prerst_act_cmd", 32'(ic), 32'(mk_iss(SCH_ACTIVE, 8'h11, 8'h00, 2'd3)));
        rst = 1'b1;
        #1;
        chk("midrst_iss_valid", 32'(bus_if.iss_valid), 0);
        chk("midrst_busy",      32'(bus_if.busy),      0);
        chk("midrst_cmd_ready", 32'(bus_if.cmd_ready), 0);
        chk("midrst_ref_ack",   32'(bus_if.ref_ack),   0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("postrst_idle_valid", 32'(bus_if.iss_valid), 0);
            @(posedge clk); #1;
        end
        send_cmd(mk_cmd(1'b1, 8'h20, 8'h06, 2'd2, 1'b1), acc);
        wait_iss(xc, ic);
        chk("postrst_act_cycle", 32'(xc - acc), 1);
        chk("postrst_act_cmd", 32'(ic), 32'(mk_iss(SCH_ACTIVE, 8'h20, 8'h06, 2'd2)));
        acc = xc;
        wait_iss(xc, ic);
        chk("postrst_rda_cycle", 32'(xc - acc), 10);
        chk("postrst_rda_cmd", 32'(ic), 32'(mk_iss(SCH_RDA, 8'h20, 8'h06, 2'd2)));

        // Refresh with banks 0 and 3 open, colliding with a host command
        send_cmd(mk_cmd(1'b1, 8'h01, 8'h00, 2'd0, 1'b0), acc);
        wait_iss(xc, ic);
        wait_iss(xc, ic);
        send_cmd(mk_cmd(1'b1, 8'h02, 8'h00, 2'd3, 1'b0), acc);
        wait_iss(act3, ic);
        chk("b3_act_cmd", 32'(ic), 32'(mk_iss(SCH_ACTIVE, 8'h02, 8'h00, 2'd3)));
        wait_iss(xc, ic);
        chk("b3_rd_cycle", 32'(xc - act3), 4);
        bus_if.ref_req   = 1'b1;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_in    = mk_cmd(1'b1, 8'h05, 8'h01, 2'd1, 1'b0);
        @(negedge clk);
        chk("ref_blocks_ready", 32'(bus_if.cmd_ready), 0);
        @(posedge clk); #1;
        wait_iss(xc, ic);
        chk("ref_pre0_cycle", 32'(xc - act3), 6);
        chk("ref_pre0_cmd", 32'(ic), 32'(mk_iss(SCH_PRECHARGE, 8'h02, 8'h00, 2'd0)));
        wait_iss(pre3, ic);
        chk("ref_pre3_cycle", 32'(pre3 - act3), 10);
        chk("ref_pre3_cmd", 32'(ic), 32'(mk_iss(SCH_PRECHARGE, 8'h02, 8'h00, 2'd3)));
        wait_iss(refc, ic);
        chk("ref_cycle", 32'(refc - pre3), 4);
        chk("ref_cmd", 32'(ic), 32'(mk_iss(SCH_REFRESH, 8'h00, 8'h00, 2'd0)));
        ackc = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (bus_if.ref_ack) begin
                ackc = cyc;
                break;
            end
            chk("ref_no_early_ready", 32'(bus_if.cmd_ready), 0);
            @(posedge clk); #1;
        end
        bus_if.ref_req = 1'b0;
        chk("ref_ack_cycle", 32'(ackc - refc), 30);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ref_ack_pulse", 32'(bus_if.ref_ack), 0);
        chk("post_ref_ready", 32'(bus_if.cmd_ready), 1);
        @(posedge clk); #1;
        bus_if.cmd_valid = 1'b0;
        wait_iss(xc, ic);
        chk("post_ref_act_cycle", 32'(xc - ackc), 2);
        chk("post_ref_act_cmd", 32'(ic), 32'(mk_iss(SCH_ACTIVE, 8'h05, 8'h01, 2'd1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
